pending_event_encoder: RTL
==========================

# pending_event_encoder

Parametrised, registered successor to the combinational one-hot encoders in the combinational library. Captures event pulses on N request lines into a sticky pending register and emits their bit indices as encoded values, one per cycle, over a valid/ready handshake. Selection is fixed-priority or round-robin. Sits between interrupt/event sources and a single consumer that processes one index at a time.

## Interface
Parameters:
- N, default 8: number of request lines; legal range 2..256.
- RR, default 0: 0 = fixed priority, where the lowest index wins; 1 = round-robin.
- W, default $clog2(N): derived localparam, not overridable; width of index.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- req_in, input, N: event pulses; each bit high for one cycle means one event for that index.
- clr, input, 1: synchronous flush of all pending events and the output stage.
- out_valid, output, 1: out_idx holds a valid index.
- out_ready, input, 1: consumer accepts; handshake when out_valid && out_ready.
- out_idx, output, W: encoded index of the presented event.
- pending, output, N: registered sticky pending bits, excluding the presented one.
- overflow, output, 1: registered one-cycle pulse; an event merged into an already-pending bit.

## Operation
- Storage:
  - pending[N-1:0] holds waiting events.
  - The output register (out_valid, out_idx) holds the presented event.
  - An event lives in exactly one place.
- Load condition: load = !out_valid || (out_valid && out_ready).
- On load with pending != 0:
  - Select index s.
  - Set out_idx <= s and out_valid <= 1.
  - Clear pending[s].
- On load with pending == 0: out_valid <= 0. out_idx holds its last value; it is don't-care when invalid.
- Capture: pending_next = (pending & ~sel_clear) | req_in.
  - A req_in bit for the index being moved out this cycle re-sets that bit. It counts as a new event, not an overflow.
- Overflow: overflow <= |(req_in & pending & ~sel_clear). Merged events are lost; one pulse per cycle regardless of how many bits merged.
- Selection, RR=0: s = lowest set index of pending.
- Selection, RR=1:
  - Keep pointer ptr (W bits, reset 0).
  - s = first set index searching ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - On each load with pending != 0, ptr <= s+1, wrapping N-1 -> 0. For non-power-of-two N, wrap explicitly; do not rely on W-bit overflow.
- clr has priority over everything in the same cycle:
  - pending <= 0, out_valid <= 0, overflow <= 0, ptr <= 0.
  - req_in in that cycle is dropped.
- Reset values: pending=0, out_valid=0, out_idx=0, overflow=0, ptr=0.

## Timing
- Latency from an idle block: req_in[i] sampled at edge t sets pending[i] after t; out_valid=1 with out_idx=i after edge t+1, so 2 cycles.
- Throughput: one index per cycle while out_ready=1 and events are pending.
- Hold rule: while out_valid && !out_ready, out_idx and out_valid are stable. Pending keeps accepting events.
- Handshake: out_valid must not depend combinationally on out_ready. All outputs are registered.
- Reset mid-operation: asynchronous assertion clears all state immediately. Deassertion is synchronised externally; the first active edge behaves as from reset.

## Structure
- Shared package (encoder_pkg): RR mode constants (ENC_FIXED=0, ENC_RR=1) and a function for the W computation with minimum 1.
- One natural sub-module: prio_select.
  - Combinational; inputs vector and start pointer, outputs found and index.
  - Fixed mode uses start=0. Implement round-robin as a double-width masked search.
- Top level holds the pending register, output register, pointer and overflow flag.

## Test plan
1. Reset, then pulse req_in=8'b1010_0100 (N=8, RR=0) with out_ready=1 -> out_idx sequence 2, 5, 7 on consecutive cycles starting 2 cycles after the pulse; then out_valid=0 and pending=0.
2. RR=1: hold out_ready=0 and inject 8'b1111_1111, then release -> out_idx 0…7 in order. Re-inject 8'b1000_0001 after idx 3 is consumed -> next indices are 4, 5, 6, 7, then 0, showing the wrap.
3. Backpressure: present idx 3 with out_ready=0 for 5 cycles while req_in pulses bit 6 -> out_idx stays 3 and pending[6]=1. Raise out_ready -> idx 3 then idx 6.
4. Overflow: pending[4]=1 held; pulse req_in[4] again -> overflow=1 for exactly one cycle and idx 4 is emitted once. A pulse of bit s on its own move-out cycle emits s twice with no overflow.
5. clr coincident with req_in=8'h0F while out_valid=1 -> next cycle out_valid=0, pending=0, overflow=0 and no index emitted.
6. N=5, RR=1: all bits requested repeatedly -> index sequence 0, 1, 2, 3, 4, 0, …; never 5–7. Assert rst_n low mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/encoder_pkg.sv
// Shared constants and helpers for the encoder family: selection mode
// encodings and the index-width calculation.
package encoder_pkg;

    localparam int ENC_FIXED = 0;
    localparam int ENC_RR    = 1;

    // Index width for n request lines, never narrower than one bit.
    function automatic int enc_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pending_event_encoder_prio_select.sv
// Combinational priority search: first set bit of vec at or after start,
// wrapping past N-1 back to 0.
module prio_select #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] idx
);

    localparam logic [W:0] NW = N[W:0];

    // Lower half keeps only bits at or above start; upper half is the full
    // vector, so the lowest set bit of the concatenation is the wrapped winner.
    logic [2*N-1:0] dbl;
    logic [W:0]     pos;

    always_comb begin
        dbl = '0;
        pos = '0;
        for (int j = 0; j < N; j++) begin
            dbl[j]     = vec[j] && (j >= int'(start));
            dbl[j + N] = vec[j];
        end
        for (int j = 2 * N - 1; j >= 0; j--) begin
            if (dbl[j]) pos = j[W:0];
        end
    end

    assign found = |vec;
    assign idx   = (pos >= NW) ? W'(pos - NW) : pos[W-1:0];

endmodule

// File: rtl/pending_event_encoder.sv
// Sticky event capture with encoded-index output over valid/ready; fixed
// priority (lowest index) or round-robin selection.
module pending_event_encoder
    import encoder_pkg::*;
#(
    parameter  int N  = 8,
    parameter  int RR = ENC_FIXED,
    localparam int W  = enc_width(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_in,
    input  logic         clr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] pending,
    output logic         overflow
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [N-1:0] pend_p0;
    logic [W-1:0] ptr_p0;
    logic         vld_p1;
    logic [W-1:0] idx_p1;
    logic         ovf_p1;

    logic         load;
    logic         take;
    logic         found;
    logic [W-1:0] sel_idx;
    logic [W-1:0] start;
    logic [N-1:0] sel_clear;
    logic [W-1:0] ptr_next;

    assign start = (RR == ENC_RR) ? ptr_p0 : '0;

    prio_select #(
        .N (N),
        .W (W)
    ) u_sel (
        .vec   (pend_p0),
        .start (start),
        .found (found),
        .idx   (sel_idx)
    );

    assign load      = !vld_p1 || out_ready;
    assign take      = load && found;
    assign sel_clear = take ? (N'(1) << sel_idx) : '0;
    // Explicit wrap so non-power-of-two N never points past N-1.
    assign ptr_next  = (sel_idx == LAST) ? '0 : sel_idx + W'(1);

    // Stage p0: pending capture and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_p0 <= '0;
            ptr_p0  <= '0;
        end else if (clr) begin
            pend_p0 <= '0;
            ptr_p0  <= '0;
        end else begin
            pend_p0 <= (pend_p0 & ~sel_clear) | req_in;
            if (take && (RR == ENC_RR)) ptr_p0 <= ptr_next;
        end
    end

    // Stage p1: presented index, its valid, and the merge pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            idx_p1 <= '0;
            ovf_p1 <= 1'b0;
        end else if (clr) begin
            vld_p1 <= 1'b0;
            ovf_p1 <= 1'b0;
        end else begin
            ovf_p1 <= |(req_in & pend_p0 & ~sel_clear);
            if (load) vld_p1 <= found;
            if (take) idx_p1 <= sel_idx;
        end
    end

    assign out_valid = vld_p1;
    assign out_idx   = idx_p1;
    assign pending   = pend_p0;
    assign overflow  = ovf_p1;

endmodule
